// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : fetch FSM states
//   ILEN_DEFAULT  : default instruction width
//   PERF_W        : width of the optional performance counters
//   sat_incr()    : saturating increment used by the performance counters
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        FLUSH
    } fetch_state_t;

    localparam int ILEN_DEFAULT = 32;
    localparam int PERF_W       = 32;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [PERF_W-1:0] sat_incr(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// pc_reg -- program counter register for the fetch sequencer.
// Ports:
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-high; loads RESET_PC
//   load     : load load_val this cycle (takes priority over incr)
//   load_val : value to load
//   incr     : advance pc by one, wrapping modulo 2^n
//   pc       : current program counter (word address)
module pc_reg #(
    parameter int           n        = 6,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] load_val,
    input  logic         incr,
    output logic [n-1:0] pc
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (incr) begin
            pc <= pc + n'(1);   // all-ones rolls over to zero
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- fetch sequencer for the multicycle RISC-V core.
// Owns the program counter, issues one-outstanding-request instruction-memory
// fetches, hands instructions to decode over valid/ready and applies redirects
// from execute, discarding any response that belongs to a stale request.
//
// Ports:
//   clock, reset                 : rising-edge clock, asynchronous active-high reset
//   run                          : allow new fetches; 0 parks in IDLE once the
//                                  current instruction has been consumed
//   imem_req / imem_addr         : single-cycle fetch request strobe and word address
//   imem_rvalid / imem_rdata     : response strobe and instruction data
//   instr_valid/instr/instr_pc   : instruction offered to decode
//   instr_ready                  : decode accepts the instruction this cycle
//   redirect / redirect_addr     : load redirect_addr as the next fetch pc
//   perf_fetch / perf_stall      : handshake and stall counters (FETCH_PERF_EN only)
//
// Build option: define FETCH_PERF_EN to add the saturating performance counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int           n        = 6,
    parameter int           ILEN     = ILEN_DEFAULT,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              imem_req,
    output logic [n-1:0]      imem_addr,
    input  logic              imem_rvalid,
    input  logic [ILEN-1:0]   imem_rdata,
    output logic              instr_valid,
    output logic [ILEN-1:0]   instr,
    output logic [n-1:0]      instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [n-1:0]      redirect_addr
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_fetch,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    fetch_state_t state;
    logic [n-1:0] pc;
    logic         consume;

    // An instruction is consumed on a VALID handshake even when a redirect
    // arrives in the same cycle; the redirect still wins the pc update.
    assign consume   = (state == VALID) && instr_ready;
    assign imem_addr = pc;

    pc_reg #(
        .n        (n),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock    (clock),
        .reset    (reset),
        .load     (redirect),
        .load_val (redirect_addr),
        .incr     (consume),
        .pc       (pc)
    );

    // imem_req and instr_valid are registered alongside the state: each is
    // high exactly while the FSM sits in REQ or VALID respectively.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the instruction register is reset too, so decode never
            // sees a leftover instruction after reset.
            state       <= IDLE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A redirect here only moves pc; run alone decides the move.
                    if (run) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    // The request already went out with the old pc; its
                    // response must be swallowed if a redirect lands now.
                    state <= redirect ? FLUSH : WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            state       <= VALID;
                            instr_valid <= 1'b1;
                        end
                    end else if (redirect) begin
                        state <= FLUSH;
                    end
                end
                VALID: begin
                    if (redirect || (instr_ready && run)) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else if (instr_ready) begin
                        state <= IDLE;
                    end else begin
                        instr_valid <= 1'b1;
                    end
                end
                FLUSH: begin
                    // Wait out the stale response; pc already holds the target.
                    if (imem_rvalid) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (consume) begin
                perf_fetch <= sat_incr(perf_fetch);
            end
            if ((state == VALID) && !instr_ready) begin
                perf_stall <= sat_incr(perf_stall);
            end
        end
    end
`endif

    // A response may only arrive while a request is outstanding.
    rvalid_outstanding: assert property (
        @(posedge clock) disable iff (reset)
        imem_rvalid |-> ((state == WAIT) || (state == FLUSH))
    ) else $error("imem_rvalid with no outstanding request");

endmodule
